// File: rtl/memory_r2_tank_port.sv
// -----------------------------------------------------------------------------
// memory_r2_tank_port
//
// Access controller for one mercury tank of the regenerative store.
//
// The tank is a 576-bit delay line (32 slots x 18 bit periods). Its output is
// r2_mob and its input is r2_mib. While the controller is idle it recirculates
// r2_mob into r2_mib, so the tank keeps its contents. A free-running position
// counter (slot_pos, bit_pos) names the bit that is on r2_mob in each cycle.
// Because the loop is exactly one circulation long, a bit driven onto r2_mib
// at position P is the bit seen on r2_mob the next time the counter reads P.
//
// Ports
//   r2_clk     bit-period clock
//   r2_rst_n   synchronous reset, active low. While it is low the tank
//              recirculates, so its contents survive reset.
//   r2_mob     serial bit emerging from the tank
//   r2_mib     serial bit entering the tank (combinational)
//   acc_req    word access request, taken only while acc_ready = 1
//   acc_we     1 = write, 0 = read. Sampled on acceptance.
//   acc_addr   slot number. Sampled on acceptance.
//   acc_wdata  17-bit write word. Sampled on acceptance.
//   clr_req    clear-whole-tank request. Beats acc_req in the same cycle.
//   acc_ready  idle; a request presented now is accepted
//   acc_done   one-cycle pulse when an access or a clear completes
//   acc_rdata  last word read, held until the next read completes
//   slot_pos   slot of the bit currently on r2_mob
//   bit_pos    bit index (0..17) of the bit currently on r2_mob
// -----------------------------------------------------------------------------
module memory_r2_tank_port #(
   parameter int SLOT_BITS = 18,
   parameter int SLOTS     = 32
) (
   input  logic        r2_clk,
   input  logic        r2_rst_n,
   input  logic        r2_mob,
   output logic        r2_mib,
   input  logic        acc_req,
   input  logic        acc_we,
   input  logic [4:0]  acc_addr,
   input  logic [16:0] acc_wdata,
   input  logic        clr_req,
   output logic        acc_ready,
   output logic        acc_done,
   output logic [16:0] acc_rdata,
   output logic [4:0]  slot_pos,
   output logic [4:0]  bit_pos
);

   localparam logic [4:0] GAP_BIT   = 5'(SLOT_BITS - 1);
   localparam logic [4:0] LAST_SLOT = 5'(SLOTS - 1);
   localparam logic [9:0] CLR_LAST  = 10'(SLOT_BITS * SLOTS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_XFER  = 2'd2,
      ST_CLEAR = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic        we_q;
   logic [4:0]  addr_q;
   logic [16:0] wdata_q;
   logic [16:0] rbuf;
   logic [9:0]  clr_cnt;

   logic        at_gap;
   logic [4:0]  slot_nxt;
   logic        idle_hit;
   logic        wait_hit;
   logic        accept_clr;
   logic        accept_acc;
   logic        xfer_last;
   logic        clr_last;

   // ---- position counter: never stalls, tracks the bit on r2_mob ----
   always_ff @(posedge r2_clk) begin
      if (!r2_rst_n) begin
         slot_pos <= '0;
         bit_pos  <= '0;
      end else if (bit_pos == GAP_BIT) begin
         bit_pos  <= '0;
         slot_pos <= slot_nxt;
      end else begin
         bit_pos  <= bit_pos + 5'd1;
      end
   end

   assign at_gap   = (bit_pos == GAP_BIT);
   assign slot_nxt = (slot_pos == LAST_SLOT) ? 5'd0 : slot_pos + 5'd1;

   // The transfer state must be present during the cycle whose position is
   // (addr,0), so the decision is taken one cycle earlier, at (addr-1,17).
   // An acceptance at (addr,0) therefore waits a full circulation.
   assign idle_hit   = at_gap && (slot_nxt == acc_addr);
   assign wait_hit   = at_gap && (slot_nxt == addr_q);

   assign accept_clr = (state == ST_IDLE) && clr_req;
   assign accept_acc = (state == ST_IDLE) && !clr_req && acc_req;
   assign xfer_last  = (state == ST_XFER) && at_gap;
   assign clr_last   = (state == ST_CLEAR) && (clr_cnt == CLR_LAST);

   // ---- state register ----
   always_ff @(posedge r2_clk) begin
      if (!r2_rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---- next-state logic ----
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (clr_req) begin
               state_nxt = ST_CLEAR;
            end else if (acc_req) begin
               state_nxt = idle_hit ? ST_XFER : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (wait_hit) begin
               state_nxt = ST_XFER;
            end
         end
         ST_XFER: begin
            if (at_gap) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_CLEAR: begin
            if (clr_cnt == CLR_LAST) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ---- outputs: tank input and handshake ----
   always_comb begin
      acc_ready = (state == ST_IDLE);
      r2_mib    = r2_mob;
      if (r2_rst_n) begin
         case (state)
            ST_XFER: begin
               // wdata_q shifts down once per transfer bit, so bit 0 is
               // always the bit due now; the gap is written as zero.
               if (we_q) begin
                  r2_mib = at_gap ? 1'b0 : wdata_q[0];
               end
            end
            ST_CLEAR: r2_mib = 1'b0;
            default:  r2_mib = r2_mob;
         endcase
      end
   end

   // ---- request capture and serial data shifting ----
   always_ff @(posedge r2_clk) begin
      if (accept_acc) begin
         we_q    <= acc_we;
         addr_q  <= acc_addr;
         wdata_q <= acc_wdata;
      end else if (state == ST_XFER) begin
         wdata_q <= wdata_q >> 1;
      end

      // Bits arrive LSB first; after 17 shifts bit 0 has reached rbuf[0].
      if ((state == ST_XFER) && !at_gap) begin
         rbuf <= {r2_mob, rbuf[16:1]};
      end

      if (accept_clr) begin
         clr_cnt <= '0;
      end else if (state == ST_CLEAR) begin
         clr_cnt <= clr_cnt + 10'd1;
      end
   end

   // ---- completion pulse and read result ----
   always_ff @(posedge r2_clk) begin
      if (!r2_rst_n) begin
         acc_done  <= 1'b0;
         acc_rdata <= '0;
      end else begin
         acc_done <= xfer_last || clr_last;
         if (xfer_last && !we_q) begin
            acc_rdata <= rbuf;
         end
      end
   end

endmodule

// File: tb/tb_memory_r2_tank_port.sv
module tb_memory_r2_tank_port;

   localparam int NB = 576;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mob = 1'b0;
   logic        mib;
   logic        req;
   logic        we;
   logic [4:0]  addr;
   logic [16:0] wdata;
   logic        clr;
   logic        ready;
   logic        done;
   logic [16:0] rdata;
   logic [4:0]  spos;
   logic [4:0]  bpos;

   int total = 0;
   int bad   = 0;

   bit          tank [NB];
   int          ph   = 0;
   int          mpos = 0;
   logic [16:0] gold [32];

   always #5 clk = ~clk;

   memory_r2_tank_port dut (
      .r2_clk    (clk),
      .r2_rst_n  (rst_n),
      .r2_mob    (mob),
      .r2_mib    (mib),
      .acc_req   (req),
      .acc_we    (we),
      .acc_addr  (addr),
      .acc_wdata (wdata),
      .clr_req   (clr),
      .acc_ready (ready),
      .acc_done  (done),
      .acc_rdata (rdata),
      .slot_pos  (spos),
      .bit_pos   (bpos)
   );

   // Tank plant: 576-stage delay from r2_mib to r2_mob, plus the expected
   // position (restarts at 0 on reset, otherwise counts modulo 576).
   always @(posedge clk) begin
      tank[ph] = mib;
      ph = (ph + 1) % NB;
      mob <= tank[ph];
      if (!rst_n) mpos = 0;
      else        mpos = (mpos + 1) % NB;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_pos(input int p);
      int n;
      n = 0;
      while (mpos != p && n < 600) begin
         tick;
         n++;
      end
      chk("pos_slot", 32'(spos), p / 18);
      chk("pos_bit", 32'(bpos), p % 18);
   endtask

   // One access. Expected latency and the bits a read will see are derived
   // from the tank plant contents and the current expected position.
   task automatic access(input logic w, input logic [4:0] a, input logic [16:0] wd,
                         output logic [16:0] rd, output int lat);
      int n, mp, d, p0;
      logic [16:0] pred;
      n = 0;
      while (!ready && n < 700) begin
         tick;
         n++;
      end
      chk("ready_before_req", 32'(ready), 1);
      mp = mpos;
      p0 = ph;
      d  = ((int'(a) * 18 - mp - 1 + NB) % NB) + 1;
      for (int k = 0; k < 17; k++) pred[k] = tank[(p0 + d + k) % NB];
      req = 1'b1; we = w; addr = a; wdata = wd;
      tick;
      req = 1'b0; we = 1'b0; addr = 5'($urandom); wdata = 17'($urandom);
      chk("busy_after_accept", 32'(ready), 0);
      n = 1;
      while (!done && n < 700) begin
         tick;
         n++;
      end
      lat = n;
      chk("latency", n, d + 18);
      chk("ready_with_done", 32'(ready), 1);
      rd = rdata;
      if (w) gold[a] = wd;
      else   chk("rdata_vs_tank", 32'(rd), 32'(pred));
   endtask

   initial begin
      logic [16:0] rd;
      logic [16:0] v;
      logic [4:0]  a;
      int          lat, zbad, dcnt, n;

      for (int i = 0; i < 32; i++) gold[i] = '0;
      rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; clr = 1'b0;

      // reset
      repeat (3) tick;
      chk("rst_ready", 32'(ready), 1);
      chk("rst_done", 32'(done), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_slot", 32'(spos), 0);
      chk("rst_bit", 32'(bpos), 0);
      chk("rst_mib_follows_mob", 32'(mib), 32'(mob));
      rst_n = 1'b1;

      // write then read, neighbours untouched
      access(1'b1, 5'd5, 17'h0ABCD, rd, lat);
      access(1'b0, 5'd5, '0, rd, lat);
      chk("wr_rd_slot5", 32'(rd), 32'h0ABCD);
      access(1'b0, 5'd4, '0, rd, lat);
      chk("slot4_clean", 32'(rd), 0);
      access(1'b0, 5'd6, '0, rd, lat);
      chk("slot6_clean", 32'(rd), 0);

      // random accesses against the word store
      for (int i = 0; i < 10; i++) begin
         repeat ($urandom_range(0, 40)) tick;
         a = 5'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            access(1'b1, a, 17'($urandom), rd, lat);
         end else begin
            access(1'b0, a, '0, rd, lat);
            chk("rand_read", 32'(rd), 32'(gold[a]));
         end
      end

      // latency extremes for slot 3
      wait_pos(2 * 18 + 17);
      access(1'b0, 5'd3, '0, rd, lat);
      chk("lat_min", lat, 19);
      chk("lat_min_data", 32'(rd), 32'(gold[3]));
      wait_pos(3 * 18);
      access(1'b0, 5'd3, '0, rd, lat);
      chk("lat_max", lat, 594);

      // wrap-around: slot 0 then slot 31 with the write waveform observed
      access(1'b1, 5'd0, 17'h00001, rd, lat);
      wait_pos(30 * 18 + 17);
      req = 1'b1; we = 1'b1; addr = 5'd31; wdata = 17'h1FFFF;
      tick;
      req = 1'b0; we = 1'b0;
      for (int k = 0; k < 18; k++) begin
         chk("w31_mib", 32'(mib), (k < 17) ? 1 : 0);
         chk("w31_bit", 32'(bpos), k);
         chk("w31_slot", 32'(spos), 31);
         tick;
      end
      gold[31] = 17'h1FFFF;
      chk("w31_done", 32'(done), 1);
      chk("wrap_slot", 32'(spos), 0);
      chk("wrap_bit", 32'(bpos), 0);
      access(1'b0, 5'd31, '0, rd, lat);
      chk("rd_slot31", 32'(rd), 32'h1FFFF);
      access(1'b0, 5'd0, '0, rd, lat);
      chk("rd_slot0", 32'(rd), 32'h00001);
      wait_pos(NB - 1);
      chk("gap_31_17_mib", 32'(mib), 0);
      tick;
      chk("after_31_17_slot", 32'(spos), 0);
      chk("after_31_17_bit", 32'(bpos), 0);

      // fill with index, then clear with a simultaneous access
      for (int i = 0; i < 32; i++) begin
         a = (i < 16) ? 5'(2 * i) : 5'(2 * (i - 16) + 1);
         access(1'b1, a, 17'(a), rd, lat);
      end
      access(1'b0, 5'd9, '0, rd, lat);
      chk("filled_slot9", 32'(rd), 9);
      clr = 1'b1; req = 1'b1; we = 1'b1; addr = 5'd9; wdata = 17'h1ABCD;
      tick;
      clr = 1'b0; req = 1'b0; we = 1'b0;
      chk("clr_busy", 32'(ready), 0);
      zbad = 0; dcnt = 0;
      for (int i = 0; i < NB; i++) begin
         if (mib !== 1'b0) zbad++;
         if (done !== 1'b0) dcnt++;
         tick;
      end
      chk("clr_zero_cycles_bad", zbad, 0);
      chk("clr_early_done", dcnt, 0);
      chk("clr_done_577", 32'(done), 1);
      for (int i = 0; i < 32; i++) gold[i] = '0;
      tick;
      chk("no_queued_access", 32'(done), 0);
      for (int i = 0; i < 32; i++) begin
         a = (i < 16) ? 5'(2 * i) : 5'(2 * (i - 16) + 1);
         access(1'b0, a, '0, rd, lat);
         chk("clr_read_zero", 32'(rd), 0);
      end

      // reset during XFER of a read of slot 7 (all slots hold v)
      v = 17'($urandom) | 17'h00100;
      for (int i = 0; i < 32; i++) begin
         a = (i < 16) ? 5'(2 * i) : 5'(2 * (i - 16) + 1);
         access(1'b1, a, v, rd, lat);
      end
      wait_pos(6 * 18 + 17);
      req = 1'b1; we = 1'b0; addr = 5'd7;
      tick;
      req = 1'b0;
      n = 0;
      while (mpos != 7 * 18 + 15 && n < 40) begin
         tick;
         n++;
      end
      chk("mid_xfer_slot", 32'(spos), 7);
      chk("mid_xfer_busy", 32'(ready), 0);
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("rst_mid_mib", 32'(mib), 32'(mob));
         chk("rst_mid_ready", 32'(ready), 1);
         chk("rst_mid_done", 32'(done), 0);
         chk("rst_mid_rdata", 32'(rdata), 0);
         chk("rst_mid_slot", 32'(spos), 0);
         chk("rst_mid_bit", 32'(bpos), 0);
      end
      rst_n = 1'b1;
      dcnt = 0;
      for (int i = 0; i < 650; i++) begin
         if (done !== 1'b0) dcnt++;
         tick;
      end
      chk("no_done_after_abort", dcnt, 0);
      access(1'b0, 5'd7, '0, rd, lat);
      chk("reread_slot7", 32'(rd), 32'(v));

      // busy rejection: write to slot 2 during WAIT of a read of slot 20
      req = 1'b1; we = 1'b0; addr = 5'd20;
      tick;
      req = 1'b0;
      tick;
      chk("wait_busy", 32'(ready), 0);
      req = 1'b1; we = 1'b1; addr = 5'd2; wdata = ~v;
      tick;
      req = 1'b0; we = 1'b0;
      n = 0;
      while (!done && n < 700) begin
         tick;
         n++;
      end
      chk("slot20_done", 32'(done), 1);
      chk("slot20_data", 32'(rdata), 32'(v));
      tick;
      chk("ignored_no_done", 32'(done), 0);
      access(1'b0, 5'd2, '0, rd, lat);
      chk("slot2_unchanged", 32'(rd), 32'(v));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
